// File: rtl/timer_counter.sv
// timer_counter
// Memory-mapped down-counting timer with one-shot and auto-reload modes.
// Register map (word offset = Addr[1:0], i.e. byte address bits [3:2]):
//   0 CTRL   : bit0 En, bits2:1 Mode, bit3 IM (other bits read 0)
//   1 PRESET : 32-bit reload value
//   2 COUNT  : 32-bit current count, read-only
//   3 reserved, reads 0
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset
//   Addr   word address [31:2]; only the low two bits are decoded
//   WE     full-word write strobe (already qualified by the bridge)
//   Din    write data
//   Dout   combinational read data for Addr
//   IRQ    interrupt request, flag masked by CTRL.IM
//
// state  | meaning
// S_IDLE | waiting for En; leaving it clears the irq flag
// S_LOAD | COUNT takes PRESET
// S_CNT  | counting down, saturating at 0; En=0 aborts
// S_INT  | set irq flag; one-shot modes clear En, mode 1 keeps it

module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [29:0] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] MODE_RELOAD = 2'd1;

  state_t      state;
  logic        en;
  logic [1:0]  mode;
  logic        im;
  logic [31:0] preset;
  logic [31:0] count;
  logic        flag;

  logic [1:0]  reg_sel;
  logic        ctrl_we;
  logic        preset_we;
  logic        addr_unused;

  assign reg_sel     = Addr[1:0];
  assign addr_unused = ^Addr[29:2];
  assign ctrl_we     = WE && (reg_sel == ADDR_CTRL);
  assign preset_we   = WE && (reg_sel == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      en     <= 1'b0;
      mode   <= 2'd0;
      im     <= 1'b0;
      preset <= '0;
      count  <= '0;
      flag   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en) begin
            state <= S_LOAD;
            flag  <= 1'b0;
          end
        end
        S_LOAD: begin
          count <= preset;
          state <= S_CNT;
        end
        S_CNT: begin
          // The <=1 branch saturates, so PRESET=0 behaves like PRESET=1.
          if (!en) begin
            state <= S_IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            count <= '0;
            state <= S_INT;
          end
        end
        S_INT: begin
          flag  <= 1'b1;
          if (mode != MODE_RELOAD) en <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Software CTRL writes come last so they override the FSM's En clear
      // and its flag set in the same cycle.
      if (ctrl_we) begin
        en   <= Din[0];
        mode <= Din[2:1];
        im   <= Din[3];
        flag <= 1'b0;
      end
      if (preset_we) preset <= Din;
    end
  end

  assign IRQ = flag & im;

  always_comb begin
    Dout = '0;
    case (reg_sel)
      ADDR_CTRL:   Dout = {28'd0, im, mode, en};
      ADDR_PRESET: Dout = preset;
      ADDR_COUNT:  Dout = count;
      default:     Dout = '0;
    endcase
  end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable timer that sits downstream of the CPU's data port, behind the system bridge, and feeds one bit of the CPU's `HWInt` bus. The bridge decodes the timer's window, drives word-aligned register reads and writes, and returns `Dout` on `m_data_rdata`. The timer counts down from a software-loaded preset. It raises `IRQ` either once (mode 0) or periodically with auto-reload (mode 1).

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; one clock for the whole block.
- `reset`  in  1  synchronous, active-high reset.
- `Addr`  in  30  word address `[31:2]`; only `Addr[3:2]` is decoded.
  - 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `WE`  in  1  full-word write strobe, already gated by the bridge (chip select, no pending `Req`).
- `Din`  in  32  write data.
- `Dout`  out  32  combinational read data for the current `Addr`.
- `IRQ`  out  1  interrupt request to `HWInt`; registered-level, driven from the FSM flag.

## Operation
Registers:
- **CTRL**
  - bit0 En, bits2:1 Mode, bit3 IM.
  - Bits 31:4 read 0 and writes to them are discarded.
  - Mode values: 0 = one-shot, 1 = auto-reload. Modes 2 and 3 behave as mode 0.
- **PRESET**: 32-bit, read/write.
- **COUNT**: 32-bit, read-only; writes are ignored.
- Reserved offset 3 reads 0; writes to it are ignored.

FSM states and transitions (all evaluated on the clock edge):
- **IDLE**: if En=1, go to LOAD and clear the irq flag.
- **LOAD**: COUNT <= PRESET; go to CNT.
- **CNT**
  - If En=0: go to IDLE; COUNT holds its value.
  - Else if COUNT > 1: COUNT <= COUNT − 1 (unsigned).
  - Else: COUNT <= 0; go to INT.
- **INT**: set the irq flag and go to IDLE.
  - Mode 0: also clear En.
  - Mode 1: leave En set, so the timer reloads.
- `IRQ = flag & IM`.

Write rules:
- A CTRL write also clears the irq flag.
- A software write to CTRL in the same cycle that INT clears En: the software value wins.
- A PRESET write during CNT does not affect the current count; it is used at the next LOAD.
- A write to CTRL.En=0 during LOAD or CNT aborts the run.
  - The FSM returns to IDLE on the next CNT edge, or after LOAD completes.
  - The irq flag is not set.
- Arithmetic: the COUNT decrement never wraps, because the `COUNT ≤ 1` branch saturates at 0. PRESET=0 behaves identically to PRESET=1.

## Timing
- **Reset values**: CTRL=0, PRESET=0, COUNT=0, state IDLE, flag=0, `IRQ`=0.
  - `Dout` reflects the reset registers in the same cycle reset deasserts.
- **Reset mid-operation**: returns all of the above to reset values at the next edge, from any state.
- **Write latency**: a write at edge t is visible on `Dout` after edge t.
- **Run sequence** for a CTRL write with En=1 at edge t and PRESET=N ≥ 1:
  - Edge t+1: IDLE → LOAD.
  - Edge t+2: COUNT = N, state CNT.
  - Edge t+2+k: COUNT = N−k, for k < N.
  - Edge t+2+N: COUNT = 0, state INT.
  - Edge t+3+N: state IDLE, flag = 1.
- **Mode 0**: `IRQ` rises after edge t+3+N if IM=1. It stays high until the next CTRL write or the next LOAD entry.
- **Mode 1**
  - Flag is set at edge t+3+N and cleared at the IDLE → LOAD edge t+4+N, so `IRQ` is high for exactly 1 cycle.
  - Period is N+3 cycles.
- **IM change**: toggling IM masks or unmasks `IRQ` combinationally; the flag itself is unchanged by IM.

## Test plan
- **Reset**: after reset, reads of offsets 0/1/2/3 → 0 and `IRQ`=0. Write CTRL=0xFFFF_FFFF, read back → 0x0000_000F.
- **Mode 0 one-shot**: PRESET=5, CTRL=0x9 at edge t.
  - COUNT reads 5,4,3,2,1,0 at edges t+2..t+7.
  - `IRQ`=1 from edge t+8, with CTRL.En=0.
  - A later write CTRL=0x8 drops `IRQ` the next cycle.
- **Mode 1 periodic**: PRESET=3, CTRL=0xB.
  - `IRQ` pulses high for exactly 1 cycle every 6 cycles.
  - Over 30 cycles: 5 pulses; COUNT never reads above 3.
- **Mask**: mode 0, PRESET=2, IM=0.
  - After expiry `IRQ`=0.
  - Writing CTRL with IM=1 and En=0 clears the flag, so `IRQ` stays 0.
- **Abort and preset edge cases**
  - PRESET=100, enable, then write CTRL=0x8 at COUNT=97: FSM goes to IDLE, COUNT holds 96 or 97, and no `IRQ` occurs.
  - PRESET=0, enable: `IRQ` rises after 4 edges, same as PRESET=1.
- **Reset mid-count**: PRESET=10 in mode 1, assert reset at COUNT=4.
  - Next edge: COUNT=0, CTRL=0, `IRQ`=0.
  - No further activity until re-enabled.
